// File: rtl/mem_dump_pkg.sv
// Shared definitions for the data-memory dump reader: FSM state encoding and default widths.
package mem_dump_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 6;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WAIT   = 3'd2,
        SEND   = 3'd3,
        FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/mem_dump_reader_if.sv
// Bundles the synchronous memory read port and the address/data output stream of the dump reader.
interface mem_dump_reader_if
    import mem_dump_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  mem_read_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    // The reader drives the memory port and the stream; memory and consumer sit on the slave side.
    modport master (
        output mem_read_en, mem_addr, out_valid, out_addr, out_data, out_last,
        input  mem_read_data, out_ready
    );

    modport slave (
        input  mem_read_en, mem_addr, out_valid, out_addr, out_data, out_last,
        output mem_read_data, out_ready
    );
endinterface

// File: rtl/mem_dump_reader.sv
// Walks a word range of data memory through a one-cycle-latency read port and streams each
// word out as an address/data beat, pulsing done when the range is exhausted.
module mem_dump_reader
    import mem_dump_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    mem_dump_reader_if.master     bus,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH:0]   remaining;

    // Every output is a register loaded on the transition into the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cur_addr        <= '0;
            remaining       <= '0;
            bus.mem_read_en <= 1'b0;
            bus.mem_addr    <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_addr    <= '0;
            bus.out_data    <= '0;
            bus.out_last    <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            bus.mem_read_en <= 1'b0;
            done            <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (word_count != '0) begin
                            cur_addr        <= base_addr;
                            remaining       <= word_count;
                            bus.mem_read_en <= 1'b1;
                            bus.mem_addr    <= base_addr;
                            state           <= READ;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    bus.out_data  <= DATA_WIDTH'(bus.mem_read_data);
                    bus.out_addr  <= cur_addr;
                    bus.out_last  <= (remaining == ONE);
                    bus.out_valid <= 1'b1;
                    state         <= SEND;
                end
                SEND: begin
                    // Beat is held untouched until the consumer takes it.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (remaining > ONE) begin
                            remaining       <= remaining - ONE;
                            cur_addr        <= cur_addr + ADDR_WIDTH'(1);
                            bus.mem_read_en <= 1'b1;
                            bus.mem_addr    <= cur_addr + ADDR_WIDTH'(1);
                            state           <= READ;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: a timing-aware beat queue model compared every cycle,
// directed scenarios pinned with literal expectations, then randomized dumps with random backpressure.
module tb_mem_dump_reader;
    import mem_dump_pkg::*;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;
    localparam int NEVER = 32'h7fff_ffff;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic          busy;
    logic          done;

    mem_dump_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_q = '0;
    always @(posedge clk) if (bus.mem_read_en) rd_q <= mem[bus.mem_addr];
    assign bus.mem_read_data = rd_q;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } beat_t;

    beat_t exp_q[$];
    beat_t log_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    bit    armed = 0;
    bit    model_active = 0;
    bit    rand_ready = 0;
    int    start_cycle = 0;
    int    done_cycle = NEVER;
    int    next_valid_cycle = NEVER;
    int    drive_cyc = 0;
    int    last_done_cyc = -1;
    int    rd_strobes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Model: expected beats sit in a queue; a beat is due 2 cycles after its start/handshake-driven
    // read, stays up until taken, and done follows the final handshake by one cycle.
    always @(negedge clk) begin
        if (armed) begin
            logic  ev, er, eb, ed;
            beat_t head;
            ev = model_active && exp_q.size() > 0 && cyc >= next_valid_cycle;
            er = model_active && exp_q.size() > 0 && cyc == next_valid_cycle - 2;
            eb = model_active && cyc >= start_cycle;
            ed = model_active && cyc == done_cycle;
            checkOutput("out_valid", 64'(bus.out_valid), 64'(ev));
            checkOutput("mem_read_en", 64'(bus.mem_read_en), 64'(er));
            checkOutput("busy", 64'(busy), 64'(eb));
            checkOutput("done", 64'(done), 64'(ed));
            if (er) checkOutput("mem_addr", 64'(bus.mem_addr), 64'(exp_q[0].addr));
            if (ev) begin
                head = exp_q[0];
                checkOutput("out_addr", 64'(bus.out_addr), 64'(head.addr));
                checkOutput("out_data", 64'(bus.out_data), 64'(head.data));
                checkOutput("out_last", 64'(bus.out_last), 64'(head.last));
                if (bus.out_ready) begin
                    head.cyc = cyc;
                    log_q.push_back(head);
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) done_cycle = cyc + 1;
                    else next_valid_cycle = cyc + 3;
                end
            end
            if (bus.mem_read_en) rd_strobes++;
            if (done) last_done_cyc = cyc;
            if (model_active && cyc == done_cycle) model_active = 0;
            if (reset) begin
                model_active = 0;
                exp_q.delete();
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW:0] n);
        @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        if (!model_active) begin
            drive_cyc        = cyc;
            start_cycle      = cyc + 1;
            model_active     = 1;
            next_valid_cycle = cyc + 3;
            done_cycle       = (n == 0) ? cyc + 1 : NEVER;
            for (int i = 0; i < int'(n); i++) begin
                beat_t t;
                t.addr = AW'(int'(b) + i);
                t.data = mem[t.addr];
                t.last = (i == int'(n) - 1);
                t.cyc  = 0;
                exp_q.push_back(t);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitIdle(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #2;
            if (!model_active) return;
        end
        vectors++;
        miscompares++;
        $display("[TB] FAIL wait_idle: still active after %0d cycles, required idle", bound);
    endtask

    task automatic waitValid(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) return;
        end
        vectors++;
        miscompares++;
        $display("[TB] FAIL wait_valid: out_valid low after %0d cycles, required high", bound);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_out_addr", 64'(bus.out_addr), 64'd0);
        checkOutput("rst_out_data", 64'(bus.out_data), 64'd0);
        checkOutput("rst_out_last", 64'(bus.out_last), 64'd0);
    endtask

    initial begin
        logic [AW-1:0] wrap_addr [4];
        logic [AW:0]   n;
        int            saved_done;
        wrap_addr = '{6'd62, 6'd63, 6'd0, 6'd1};
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("init_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("init_mem_read_en", 64'(bus.mem_read_en), 64'd0);
        checkOutput("init_mem_addr", 64'(bus.mem_addr), 64'd0);
        checkOutput("init_busy", 64'(busy), 64'd0);
        checkOutput("init_done", 64'(done), 64'd0);
        checkOutput("init_out_data", 64'(bus.out_data), 64'd0);
        armed = 1;

        // Basic three-word dump with the consumer always ready.
        log_q.delete();
        applyStimulus(6'd4, 7'd3);
        waitIdle(200);
        checkOutput("t1_beats", 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) begin
            checkOutput("t1_addr0", 64'(log_q[0].addr), 64'd4);
            checkOutput("t1_data0", 64'(log_q[0].data), 64'h1000_0004);
            checkOutput("t1_last0", 64'(log_q[0].last), 64'd0);
            checkOutput("t1_addr1", 64'(log_q[1].addr), 64'd5);
            checkOutput("t1_addr2", 64'(log_q[2].addr), 64'd6);
            checkOutput("t1_data2", 64'(log_q[2].data), 64'h1000_0006);
            checkOutput("t1_last2", 64'(log_q[2].last), 64'd1);
            checkOutput("t1_latency", 64'(log_q[0].cyc - drive_cyc), 64'd3);
            checkOutput("t1_spacing", 64'(log_q[1].cyc - log_q[0].cyc), 64'd3);
            checkOutput("t1_done_after_last", 64'(last_done_cyc - log_q[2].cyc), 64'd1);
        end

        // Backpressure holds the first beat steady.
        log_q.delete();
        bus.out_ready = 1'b0;
        applyStimulus(6'd0, 7'd2);
        waitValid(20);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("t2_hold_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("t2_hold_addr", 64'(bus.out_addr), 64'd0);
        checkOutput("t2_hold_data", 64'(bus.out_data), 64'h1000_0000);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        waitIdle(200);
        checkOutput("t2_beats", 64'(log_q.size()), 64'd2);

        // Address wrap through zero.
        log_q.delete();
        applyStimulus(6'd62, 7'd4);
        waitIdle(200);
        checkOutput("t3_beats", 64'(log_q.size()), 64'd4);
        if (log_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("t3_addr", 64'(log_q[i].addr), 64'(wrap_addr[i]));
                checkOutput("t3_last", 64'(log_q[i].last), 64'(i == 3));
            end
        end

        // Zero-length dump touches nothing and finishes immediately.
        log_q.delete();
        rd_strobes = 0;
        applyStimulus(6'd9, 7'd0);
        waitIdle(50);
        checkOutput("t4_beats", 64'(log_q.size()), 64'd0);
        checkOutput("t4_reads", 64'(rd_strobes), 64'd0);
        checkOutput("t4_done_delay", 64'(last_done_cyc - drive_cyc), 64'd1);

        // A second start while busy is ignored.
        log_q.delete();
        applyStimulus(6'd0, 7'd4);
        repeat (2) @(posedge clk);
        applyStimulus(6'd10, 7'd4);
        waitIdle(200);
        checkOutput("t5_beats", 64'(log_q.size()), 64'd4);
        if (log_q.size() == 4) begin
            for (int i = 0; i < 4; i++) checkOutput("t5_addr", 64'(log_q[i].addr), 64'(i));
        end

        // Reset during the second beat's SEND abandons the dump without done.
        log_q.delete();
        saved_done = last_done_cyc;
        applyStimulus(6'd8, 7'd3);
        for (int i = 0; i < 50 && log_q.size() < 1; i++) @(posedge clk);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        waitValid(20);
        doReset();
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        checkOutput("t6_no_done", 64'(last_done_cyc), 64'(saved_done));
        log_q.delete();
        applyStimulus(6'd20, 7'd1);
        waitIdle(100);
        checkOutput("t6_beats", 64'(log_q.size()), 64'd1);
        if (log_q.size() == 1) begin
            checkOutput("t6_addr", 64'(log_q[0].addr), 64'd20);
            checkOutput("t6_data", 64'(log_q[0].data), 64'h1000_0014);
            checkOutput("t6_last", 64'(log_q[0].last), 64'd1);
        end

        // Randomized dumps with random memory, backpressure and stray start pulses.
        rand_ready = 1;
        for (int iter = 0; iter < 40; iter++) begin
            waitIdle(4000);
            for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
            case ($urandom_range(0, 9))
                0:       n = 7'd0;
                1:       n = 7'd64;
                default: n = 7'($urandom_range(1, 8));
            endcase
            applyStimulus(6'($urandom_range(0, DEPTH - 1)), n);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 6)) @(posedge clk);
                applyStimulus(6'($urandom_range(0, DEPTH - 1)), 7'($urandom_range(0, 8)));
            end
        end
        waitIdle(4000);
        rand_ready = 0;
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
